// File: rtl/uart_rx_param.sv
// uart_rx_param
// Parametrised UART receiver. It oversamples the serial line with a baud
// counter, decodes start/data/parity/stop bits, flags parity and framing
// errors, and queues each received word in a first-word-fall-through FIFO.
//
// Ports
//   clk            system clock
//   reset          synchronous active-high reset
//   RX_Serial      asynchronous serial input, idle high
//   rx_data        data of the FIFO head entry
//   rx_parity_err  parity error flag of the head entry
//   rx_frame_err   framing error flag of the head entry
//   rx_valid       FIFO holds at least one entry
//   rx_ready       consumer takes the head entry when rx_valid is high
//   rx_overrun     one-cycle pulse when a finished frame is dropped (FIFO full)
//   rx_count       current FIFO occupancy
module uart_rx_param #(
  parameter int FREQ       = 100000000,
  parameter int BAUDRATE   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          RX_Serial,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count
);

  localparam int DIV     = FREQ / BAUDRATE;
  localparam int CNT_W   = $clog2(DIV);
  localparam int IDX_W   = $clog2(DATA_BITS);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_BITS + 2;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(DIV / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_BITS - 1);
  localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // --------------------------------------------------------------------
  // Input synchronizer (resets to the idle-high line level)
  // --------------------------------------------------------------------
  logic sync1_reg, sync2_reg;
  logic rxs;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= RX_Serial;
      sync2_reg <= sync1_reg;
    end
  end

  assign rxs = sync2_reg;

  // --------------------------------------------------------------------
  // Frame decoder
  // --------------------------------------------------------------------
  state_t               state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic                 stop_idx_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 perr_reg;
  logic                 ferr_reg;
  logic                 sample;
  logic                 stop_last;
  logic                 push_en;
  logic [ENTRY_W-1:0]   push_entry;

  assign sample    = (cnt_reg == '0);
  assign stop_last = (stop_idx_reg == 1'(STOP_BITS - 1));

  // The word is pushed on the last stop sample itself, so the current
  // stop-bit level is folded into the framing flag combinationally.
  assign push_en    = (state_reg == STOP) && sample && stop_last;
  assign push_entry = {data_reg, perr_reg, ferr_reg | ~rxs};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      stop_idx_reg <= 1'b0;
      data_reg     <= '0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
    end else begin
      // Baud counter runs in every non-idle state; the sample event is at 0.
      if (state_reg != IDLE) begin
        cnt_reg <= sample ? CNT_RELOAD : cnt_reg - CNT_W'(1);
      end
      case (state_reg)
        IDLE: begin
          if (!rxs) begin
            // First sample lands half a bit in, i.e. the start-bit centre.
            cnt_reg   <= CNT_HALF;
            state_reg <= START;
          end
        end
        START: begin
          if (sample) begin
            if (!rxs) begin
              idx_reg   <= '0;
              perr_reg  <= 1'b0;
              ferr_reg  <= 1'b0;
              state_reg <= DATA;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        DATA: begin
          if (sample) begin
            data_reg[idx_reg] <= rxs;
            idx_reg           <= idx_reg + IDX_W'(1);
            if (idx_reg == LAST_IDX) begin
              stop_idx_reg <= 1'b0;
              state_reg    <= (PARITY != 0) ? PAR : STOP;
            end
          end
        end
        PAR: begin
          if (sample) begin
            perr_reg     <= ((^data_reg) ^ rxs) != (PARITY == 1);
            stop_idx_reg <= 1'b0;
            state_reg    <= STOP;
          end
        end
        STOP: begin
          if (sample) begin
            if (!rxs) ferr_reg <= 1'b1;
            if (stop_last) state_reg    <= IDLE;
            else           stop_idx_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------
  // Receive FIFO (first-word fall-through via a registered head copy)
  // --------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg, rd_next;
  logic [OCC_W-1:0]   count_reg, count_next;
  logic [ENTRY_W-1:0] head_reg;
  logic               overrun_reg;
  logic               full, pop, push_ok, bypass;

  assign full    = (count_reg == OCC_FULL);
  assign pop     = (count_reg != '0) && rx_ready;
  assign push_ok = push_en && (!full || pop);
  assign rd_next = rd_ptr_reg + PTR_W'(pop);
  // Nothing left behind the head after this cycle's pop: the new head can
  // only be the word being pushed now.
  assign bypass  = (count_reg == '0) || ((count_reg == OCC_W'(1)) && pop);

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop)      count_next = count_reg + OCC_W'(1);
    else if (!push_ok && pop) count_next = count_reg - OCC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      head_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      rd_ptr_reg  <= rd_next;
      count_reg   <= count_next;
      overrun_reg <= push_en && full && !pop;
      // Head holds its last value while the FIFO is empty.
      if (count_next != '0) head_reg <= bypass ? push_entry : mem[rd_next];
    end
  end

  assign rx_data       = head_reg[ENTRY_W-1:2];
  assign rx_parity_err = head_reg[1];
  assign rx_frame_err  = head_reg[0];
  assign rx_valid      = (count_reg != '0);
  assign rx_overrun    = overrun_reg;
  assign rx_count      = count_reg;

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  logic clk = 1'b0;
  logic reset;
  logic line [3];
  logic rdy  [3];

  always #5 clk = ~clk;

  // Instance 0: 8N1, instance 1: 8E1, instance 2: 7O2. DIV = 10 everywhere.
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic pe0, fe0, v0, ov0, pe1, fe1, v1, ov1, pe2, fe2, v2, ov2;
  logic [2:0] c0, c1, c2;

  uart_rx_param #(.FREQ(1000000), .BAUDRATE(100000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .RX_Serial(line[0]), .rx_data(d0),
    .rx_parity_err(pe0), .rx_frame_err(fe0), .rx_valid(v0), .rx_ready(rdy[0]),
    .rx_overrun(ov0), .rx_count(c0));

  uart_rx_param #(.FREQ(1000000), .BAUDRATE(100000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_par (
    .clk(clk), .reset(reset), .RX_Serial(line[1]), .rx_data(d1),
    .rx_parity_err(pe1), .rx_frame_err(fe1), .rx_valid(v1), .rx_ready(rdy[1]),
    .rx_overrun(ov1), .rx_count(c1));

  uart_rx_param #(.FREQ(1000000), .BAUDRATE(100000), .DATA_BITS(7), .PARITY(1),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_p7 (
    .clk(clk), .reset(reset), .RX_Serial(line[2]), .rx_data(d2),
    .rx_parity_err(pe2), .rx_frame_err(fe2), .rx_valid(v2), .rx_ready(rdy[2]),
    .rx_overrun(ov2), .rx_count(c2));

  int checks = 0;
  int errors = 0;
  int ov_cnt0 = 0;
  logic [10:0] q0[$], q1[$], q2[$];

  // Record every handshake ({data, perr, ferr}) and every overrun pulse.
  always @(negedge clk) begin
    if (v0 && rdy[0]) q0.push_back({1'b0, d0, pe0, fe0});
    if (v1 && rdy[1]) q1.push_back({1'b0, d1, pe1, fe1});
    if (v2 && rdy[2]) q2.push_back({2'b00, d2, pe2, fe2});
    if (ov0) ov_cnt0++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s value=%0h", tag, got);
    end
  endtask

  task automatic check_entry(input int w, input string tag, input logic [8:0] d,
                             input logic pe, input logic fe);
    logic [10:0] e;
    int n;
    case (w)
      0:       n = q0.size();
      1:       n = q1.size();
      default: n = q2.size();
    endcase
    check({tag, "_avail"}, (n > 0), 1);
    if (n > 0) begin
      case (w)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      check({tag, "_data"}, e[10:2], d);
      check({tag, "_perr"}, e[1], pe);
      check({tag, "_ferr"}, e[0], fe);
    end
  endtask

  task automatic drive_bit(input int w, input logic b);
    line[w] = b;
    repeat (10) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input int w, input logic val);
    @(posedge clk);
    #2 rdy[w] = val;
  endtask

  // pbit < 0 means no parity bit on the line.
  task automatic send_frame(input int w, input logic [8:0] d, input int nbits,
                            input int pbit, input logic s1, input logic s2,
                            input int nstop);
    drive_bit(w, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(w, d[i]);
    if (pbit >= 0) drive_bit(w, pbit[0]);
    drive_bit(w, s1);
    if (nstop > 1) drive_bit(w, s2);
    line[w] = 1'b1;
  endtask

  initial begin
    logic [8:0] rst_byte;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      line[i] = 1'b1;
      rdy[i]  = 1'b0;
    end
    repeat (5) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_valid", v0, 0);
    check("rst_count", c0, 0);
    check("rst_overrun", ov0, 0);
    check("rst_data", d0, 0);
    check("rst_perr", pe0, 0);
    check("rst_ferr", fe0, 0);

    // Plain 8N1 frame
    set_ready(0, 1'b1);
    send_frame(0, 9'h0A5, 8, -1, 1'b1, 1'b1, 1);
    idle(20);
    check_entry(0, "a5", 9'h0A5, 1'b0, 1'b0);
    check("a5_single", q0.size(), 0);

    // Stop bit low -> framing error, next frame clean
    send_frame(0, 9'h03C, 8, -1, 1'b0, 1'b1, 1);
    idle(20);
    send_frame(0, 9'h05A, 8, -1, 1'b1, 1'b1, 1);
    idle(20);
    check_entry(0, "3c_ferr", 9'h03C, 1'b0, 1'b1);
    check_entry(0, "5a_after", 9'h05A, 1'b0, 1'b0);

    // Short low glitch is rejected in START
    line[0] = 1'b0;
    idle(3);
    line[0] = 1'b1;
    idle(30);
    check("glitch_nopush", q0.size(), 0);
    check("glitch_count", c0, 0);
    check("glitch_valid", v0, 0);

    // Fill FIFO, overflow by one
    set_ready(0, 1'b0);
    ov_cnt0 = 0;
    for (int i = 1; i <= 5; i++) send_frame(0, 9'(i), 8, -1, 1'b1, 1'b1, 1);
    idle(20);
    check("full_count", c0, 4);
    check("full_overrun", ov_cnt0, 1);
    check("full_valid", v0, 1);
    check("full_head", d0, 8'h01);
    set_ready(0, 1'b1);
    idle(10);
    check_entry(0, "drain1", 9'h001, 1'b0, 1'b0);
    check_entry(0, "drain2", 9'h002, 1'b0, 1'b0);
    check_entry(0, "drain3", 9'h003, 1'b0, 1'b0);
    check_entry(0, "drain4", 9'h004, 1'b0, 1'b0);
    check("drain_empty", q0.size(), 0);
    check("drain_valid", v0, 0);
    check("drain_count", c0, 0);

    // Reset during data bit 4 with one entry already queued
    set_ready(0, 1'b0);
    send_frame(0, 9'h011, 8, -1, 1'b1, 1'b1, 1);
    idle(20);
    check("pre_rst_count", c0, 1);
    rst_byte = 9'h022;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, rst_byte[i]);
    line[0] = rst_byte[4];
    idle(5);
    reset = 1'b1;
    line[0] = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(30);
    check("midrst_valid", v0, 0);
    check("midrst_count", c0, 0);
    check("midrst_data", d0, 0);
    set_ready(0, 1'b1);
    send_frame(0, 9'h07E, 8, -1, 1'b1, 1'b1, 1);
    idle(20);
    check_entry(0, "7e_after_rst", 9'h07E, 1'b0, 1'b0);

    // Even parity: 0x03 has two ones
    set_ready(1, 1'b1);
    send_frame(1, 9'h003, 8, 1, 1'b1, 1'b1, 1);
    idle(20);
    send_frame(1, 9'h003, 8, 0, 1'b1, 1'b1, 1);
    idle(20);
    check_entry(1, "even_bad", 9'h003, 1'b1, 1'b0);
    check_entry(1, "even_ok", 9'h003, 1'b0, 1'b0);

    // 7O2: 0x55 has four ones, odd parity bit 1, second stop low
    set_ready(2, 1'b1);
    send_frame(2, 9'h055, 7, 1, 1'b1, 1'b0, 2);
    idle(30);
    check_entry(2, "7o2_stop2", 9'h055, 1'b0, 1'b1);

    check("stray0", q0.size(), 0);
    check("stray1", q1.size(), 0);
    check("stray2", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
